bist_scheduler: RTL and testbench
=================================

BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: number of per-core BIST controllers sequenced.
REQ-002 Parameter TIMEOUT, default 16384: maximum cycles allowed in WAIT per core.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clock  in  1  rising-edge clock.
REQ-005 Port reset  in  1  synchronous reset, active-low.
REQ-006 Port start  in  1  host request; its rising edge starts a session.
REQ-007 Port abort  in  1  level; cancels a running session.
REQ-008 Port core_mask  in  NUM_CORES  cores to test; latched on the accepted start edge.
REQ-009 Port bist_end  in  NUM_CORES  per-core end flag from the core controllers.
REQ-010 Port pass  in  NUM_CORES  per-core signature-match flag; valid when bist_end is high.
REQ-011 Port bist_start  out  NUM_CORES  one-cycle launch pulse per core.
REQ-012 Port busy  out  1  high from SELECT through FINISH.
REQ-013 Port done  out  1  one-cycle pulse in FINISH.
REQ-014 Port result  out  NUM_CORES  per-core pass bit; held until the next accepted start.
REQ-015 Port timeout_err  out  NUM_CORES  per-core timeout flag; held until the next accepted start.
REQ-016 Port all_pass  out  1  (result & mask_q) == mask_q; valid while done is high.
REQ-017 Port cur_core  out  clog2(NUM_CORES)  index of the core under test.

Function
REQ-018 The FSM SHALL have the states IDLE, SELECT, LAUNCH, WAIT, RECORD, FINISH; all outputs SHALL decode from registered state and registers only.
REQ-019 IDLE: a start edge (start=1, previous-cycle start=0) SHALL latch mask_q=core_mask and pending=core_mask, clear result and timeout_err, and go to SELECT.
REQ-020 SELECT: if pending==0, go to FINISH; otherwise set cur_core to the lowest set bit of pending and go to LAUNCH.
REQ-021 LAUNCH: bist_start[cur_core]=1 for exactly this one cycle (all other bits 0); clear the timer; go to WAIT.
REQ-022 bist_start[i] SHALL rise exactly 2 cycles after the cycle in which the start edge is sampled, where i is the first core.
REQ-023 WAIT: the timer SHALL increment each cycle; the block SHALL detect completion as a rising edge of bist_end[cur_core] (current=1, previous=0).
REQ-024 On completion, pass[cur_core] SHALL be captured and the FSM SHALL go to RECORD.
REQ-025 If the timer reaches TIMEOUT-1 without completion, the block SHALL set timeout_err[cur_core], record pass as 0, and go to RECORD.
REQ-026 If completion and timeout occur in the same cycle, completion SHALL take precedence and timeout_err SHALL NOT be set.
REQ-027 bist_end edges on cores other than cur_core SHALL be ignored; a bist_end already high at LAUNCH does not complete the core.
REQ-028 RECORD: write result[cur_core], clear pending[cur_core], and go to SELECT.
REQ-029 FINISH: done=1 and all_pass valid for one cycle, then go to IDLE.
REQ-030 A latched mask of 0 SHALL reach FINISH with result=0 and all_pass=1.
REQ-031 Start edges outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-032 abort=1 in any state except IDLE SHALL go to IDLE the next cycle.
REQ-033 On abort, bist_start SHALL be 0 and pending SHALL be cleared; done SHALL NOT pulse.
REQ-034 On abort, result and timeout_err SHALL keep their partial values.
REQ-035 The timer SHALL be clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-036 reset=0 at a clock edge SHALL force state=IDLE and clear bist_start, busy, done, result, timeout_err, cur_core, pending, mask_q, timer, and the previous-start and previous-bist_end registers.
REQ-037 Reset asserted mid-session SHALL override abort and all other inputs and take effect at the next edge.

Structure
REQ-038 A shared package bist_pkg SHALL hold the state enumeration and the default TIMEOUT constant.
REQ-039 The lowest-set-bit search SHALL be a sub-module bist_prio_enc (inputs: vector; outputs: index, valid).

Verification
REQ-040 NUM_CORES=4, mask=4'b1011, all cores pass after 20 cycles -> bist_start order bits 0,1,3; done once; result=4'b1011; all_pass=1.
REQ-041 mask=4'b0110, core 2 returns pass=0 -> result=4'b0010; all_pass=0; timeout_err=0.
REQ-042 TIMEOUT=64, core 1 never raises bist_end -> WAIT exits after 64 cycles; timeout_err=4'b0010; the session continues to the remaining cores.
REQ-043 abort raised during WAIT on core 0, with start re-pulsed while busy -> IDLE next cycle; no done pulse; the second start is ignored.
REQ-044 mask=0 -> done pulses 2 cycles after the start edge; all_pass=1; no bist_start pulse.
REQ-045 reset=0 during LAUNCH -> all outputs are 0 at the next edge; a fresh start then runs normally.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg
//   Shared definitions for the BIST scheduler: the sequencer state encoding
//   and the default per-core wait limit.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RECORD,
    ST_FINISH
  } bist_state_e;

  localparam int unsigned BIST_TIMEOUT_DEFAULT = 16384;

endpackage

// File: rtl/bist_prio_enc.sv
// bist_prio_enc
//   Lowest-set-bit finder used to pick the next core still waiting for test.
//   Ports:
//     vector : bits to search
//     index  : position of the lowest set bit (0 when vector is empty)
//     valid  : at least one bit of vector is set
module bist_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vector,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  // Scan from the top down so the last hit, the lowest bit, wins.
  always_comb begin
    index = '0;
    valid = |vector;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vector[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// bist_scheduler
//   Runs the per-core BIST controllers one after another, lowest core first,
//   over the cores selected by the mask latched at the start edge.
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-low reset
//     start, abort        : host session request (edge) and cancel (level)
//     core_mask           : cores to test, latched on the accepted start edge
//     bist_end, pass      : per-core end flag and signature-match flag
//     bist_start          : one-cycle launch pulse to the core under test
//     busy, done          : session in progress / one-cycle completion pulse
//     result, timeout_err : per-core pass and timeout flags, held until next start
//     all_pass            : every masked core passed (qualified by done)
//     cur_core            : index of the core under test
//
//   state  | meaning
//   IDLE   | waiting for a start edge
//   SELECT | pick the lowest pending core, or finish if none is left
//   LAUNCH | pulse bist_start for the selected core, clear the timer
//   WAIT   | wait for a rising bist_end on the selected core, or time out
//   RECORD | store the outcome and retire the core from pending
//   FINISH | pulse done with all_pass
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned TIMEOUT   = BIST_TIMEOUT_DEFAULT,
  localparam int unsigned CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned TIMER_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] bist_end,
  input  logic [NUM_CORES-1:0] pass,
  output logic [NUM_CORES-1:0] bist_start,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CORES-1:0] result,
  output logic [NUM_CORES-1:0] timeout_err,
  output logic                 all_pass,
  output logic [CORE_W-1:0]    cur_core
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  bist_state_e          state;
  logic                 start_q;
  logic [NUM_CORES-1:0] end_q;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] pending;
  logic                 pass_q;
  logic [TIMER_W-1:0]   timer;

  logic [CORE_W-1:0]    next_core;
  logic                 next_valid;
  logic                 start_edge;
  logic                 end_edge;

  assign start_edge = start & ~start_q;
  // Only a fresh rise on the core under test counts; a flag that was already
  // high when the core was launched is stale.
  assign end_edge   = bist_end[cur_core] & ~end_q[cur_core];

  bist_prio_enc #(
    .WIDTH (NUM_CORES),
    .IDX_W (CORE_W)
  ) u_prio (
    .vector (pending),
    .index  (next_core),
    .valid  (next_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      end_q       <= '0;
      mask_q      <= '0;
      pending     <= '0;
      pass_q      <= 1'b0;
      timer       <= '0;
      bist_start  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      all_pass    <= 1'b0;
      result      <= '0;
      timeout_err <= '0;
      cur_core    <= '0;
    end else begin
      start_q <= start;
      end_q   <= bist_end;
      if (abort && (state != ST_IDLE)) begin
        // result and timeout_err deliberately keep their partial values.
        state      <= ST_IDLE;
        pending    <= '0;
        bist_start <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
        all_pass   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_edge) begin
              mask_q      <= core_mask;
              pending     <= core_mask;
              result      <= '0;
              timeout_err <= '0;
              busy        <= 1'b1;
              state       <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            if (!next_valid) begin
              done     <= 1'b1;
              all_pass <= ((result & mask_q) == mask_q);
              state    <= ST_FINISH;
            end else begin
              cur_core   <= next_core;
              bist_start <= NUM_CORES'(1) << next_core;
              state      <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: begin
            bist_start <= '0;
            timer      <= '0;
            state      <= ST_WAIT;
          end
          ST_WAIT: begin
            // Completion is checked first so it wins over a same-cycle timeout.
            if (end_edge) begin
              pass_q <= pass[cur_core];
              state  <= ST_RECORD;
            end else if (timer == TIMER_LAST) begin
              timeout_err[cur_core] <= 1'b1;
              pass_q                <= 1'b0;
              state                 <= ST_RECORD;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_RECORD: begin
            result[cur_core]  <= pass_q;
            pending[cur_core] <= 1'b0;
            state             <= ST_SELECT;
          end
          ST_FINISH: begin
            done     <= 1'b0;
            all_pass <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// tb_bist_scheduler
//   Drives host sessions and emulates the per-core BIST controllers, then
//   compares the scheduler against a session-level reference model.
module tb_bist_scheduler;

  localparam int NC = 4;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NC-1:0] core_mask = '0;
  logic [NC-1:0] pass = '0;
  logic [NC-1:0] resp_end = '0;
  logic [NC-1:0] stuck = '0;
  logic [NC-1:0] bist_end;
  logic [NC-1:0] bist_start;
  logic          busy;
  logic          done;
  logic [NC-1:0] result;
  logic [NC-1:0] timeout_err;
  logic          all_pass;
  logic [1:0]    cur_core;

  int n_cmp = 0;
  int n_bad = 0;

  // Core controller emulation: delay 0 means the core never reports back.
  int cfg_delay [NC];
  bit cfg_pass  [NC];
  int cnt       [NC];
  int hold      [NC];

  assign bist_end = resp_end | stuck;

  always #5 clock = ~clock;

  bist_scheduler #(.NUM_CORES(NC), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .core_mask   (core_mask),
    .bist_end    (bist_end),
    .pass        (pass),
    .bist_start  (bist_start),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .timeout_err (timeout_err),
    .all_pass    (all_pass),
    .cur_core    (cur_core)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_resp();
    resp_end = '0;
    for (int i = 0; i < NC; i++) begin
      cnt[i]  = 0;
      hold[i] = 0;
    end
  endtask

  task automatic set_core(input int i, input int d, input bit p);
    cfg_delay[i] = d;
    cfg_pass[i]  = p;
  endtask

  // One cycle of core behaviour, called right after each sampled edge.
  task automatic respond_step();
    for (int i = 0; i < NC; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        if (hold[i] == 0) resp_end[i] = 1'b0;
      end
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          resp_end[i] = 1'b1;
          pass[i]     = cfg_pass[i];
          hold[i]     = 3;
        end
      end
      if (bist_start[i] === 1'b1 && cfg_delay[i] > 0) cnt[i] = cfg_delay[i];
    end
  endtask

  function automatic bit timed_out(input int i);
    return (stuck[i] == 1'b1) || (cfg_delay[i] == 0) || (cfg_delay[i] > TO);
  endfunction

  // Full session with reference model: launch order, timing, outcome flags.
  task automatic run_session(input logic [NC-1:0] mask, input string tag);
    int            exp_order[$];
    int            exp_n;
    int            exp_done;
    logic [NC-1:0] exp_res;
    logic [NC-1:0] exp_to;
    bit            exp_ap;
    int            first_launch;
    int            n_launch;
    int            done_cnt;
    int            done_cyc;
    bit            busy_bad;
    logic [NC-1:0] res_d;
    logic [NC-1:0] to_d;
    logic          ap_d;
    logic [NC-1:0] oh;
    int            e;

    exp_res = '0; exp_to = '0; exp_done = 1;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        exp_order.push_back(i);
        if (timed_out(i)) begin
          exp_to[i] = 1'b1;
          exp_done += 3 + TO;
        end else begin
          exp_res[i] = cfg_pass[i];
          exp_done += 3 + cfg_delay[i];
        end
      end
    end
    exp_n  = exp_order.size();
    exp_ap = ((exp_res & mask) == mask);
    first_launch = -1; n_launch = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0;
    res_d = '0; to_d = '0; ap_d = 1'b0;

    clear_resp();
    repeat (3) tick();
    core_mask = mask;
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b1) busy_bad = 1;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      tick();
      if (bist_start !== '0) begin
        n_launch++;
        if (first_launch < 0) first_launch = cyc;
        n_cmp++;
        if (exp_order.size() == 0) begin
          n_bad++;
          $display("FAIL %s launch: unexpected bist_start=%b at cycle %0d", tag, bist_start, cyc);
        end else begin
          e  = exp_order.pop_front();
          oh = '0;
          oh[e] = 1'b1;
          if (bist_start !== oh || cur_core !== 2'(e)) begin
            n_bad++;
            $display("FAIL %s launch: bist_start=%b cur_core=%0d expected %b / %0d",
                     tag, bist_start, cur_core, oh, e);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          res_d = result;
          to_d  = timeout_err;
          ap_d  = all_pass;
        end
      end
      if (busy !== (cyc <= exp_done)) busy_bad = 1;
      respond_step();
    end

    n_cmp++;
    if (n_launch != exp_n) begin
      n_bad++;
      $display("FAIL %s launch_count: got %0d expected %0d", tag, n_launch, exp_n);
    end
    n_cmp++;
    if (first_launch != ((mask != 0) ? 1 : -1)) begin
      n_bad++;
      $display("FAIL %s first_launch: got cycle %0d expected %0d", tag, first_launch,
               (mask != 0) ? 1 : -1);
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != exp_done) begin
      n_bad++;
      $display("FAIL %s done: got %0d pulses first at %0d expected 1 at %0d",
               tag, done_cnt, done_cyc, exp_done);
    end
    n_cmp++;
    if (res_d !== exp_res || to_d !== exp_to) begin
      n_bad++;
      $display("FAIL %s outcome: result=%b timeout_err=%b expected %b / %b",
               tag, res_d, to_d, exp_res, exp_to);
    end
    n_cmp++;
    if (ap_d !== exp_ap) begin
      n_bad++;
      $display("FAIL %s all_pass: got %b expected %b", tag, ap_d, exp_ap);
    end
    n_cmp++;
    if (busy_bad) begin
      n_bad++;
      $display("FAIL %s busy: busy window got wrong, expected cycles 0..%0d", tag, exp_done);
    end
    n_cmp++;
    if (result !== exp_res || timeout_err !== exp_to) begin
      n_bad++;
      $display("FAIL %s held: result=%b timeout_err=%b expected %b / %b",
               tag, result, timeout_err, exp_res, exp_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bist_start, busy, done, result, timeout_err, all_pass, cur_core} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: bist_start=%b busy=%b done=%b result=%b to=%b ap=%b cur=%0d expected all 0",
               bist_start, busy, done, result, timeout_err, all_pass, cur_core);
    end
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_all_pass();
    for (int i = 0; i < NC; i++) set_core(i, 20, 1'b1);
    run_session(4'b1011, "all_pass");
  endtask

  task automatic test_fail_core();
    set_core(1, $urandom_range(1, 30), 1'b1);
    set_core(2, $urandom_range(1, 30), 1'b0);
    run_session(4'b0110, "fail_core");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NC; i++) set_core(i, $urandom_range(1, 12), 1'b1);
    set_core(1, 0, 1'b1);
    run_session(4'b1111, "timeout");
  endtask

  // Core 0 completes on the last allowed cycle; core 1 is one cycle late.
  task automatic test_timeout_boundary();
    set_core(0, TO, 1'b1);
    set_core(1, TO + 1, 1'b1);
    run_session(4'b0011, "to_boundary");
  endtask

  // An end flag already high at launch must not complete the core.
  task automatic test_stuck_end();
    for (int i = 0; i < NC; i++) set_core(i, 6, 1'b1);
    stuck = 4'b0100;
    run_session(4'b0101, "stuck_end");
    stuck = '0;
  endtask

  task automatic test_empty_mask();
    run_session(4'b0000, "empty_mask");
  endtask

  task automatic test_abort();
    int l1;
    bit reached;
    bit seen;
    set_core(0, 3, 1'b1);
    set_core(1, 0, 1'b1);
    set_core(3, 5, 1'b1);
    clear_resp();
    repeat (3) tick();
    core_mask = 4'b1011;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    l1      = -1;
    reached = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (bist_start[1] === 1'b1 && l1 < 0) l1 = cyc;
      if (l1 > 0) begin
        if (cyc == l1 + 3) start = 1'b1;
        if (cyc == l1 + 4) start = 1'b0;
        if (cyc == l1 + 5) abort = 1'b1;
        if (cyc == l1 + 6) begin
          abort   = 1'b0;
          reached = 1;
          break;
        end
      end
      respond_step();
    end
    n_cmp++;
    if (!reached || busy !== 1'b0 || done !== 1'b0 || bist_start !== '0) begin
      n_bad++;
      $display("FAIL abort_idle: reached=%0d busy=%b done=%b bist_start=%b expected 1/0/0/0",
               reached, busy, done, bist_start);
    end
    seen = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || bist_start !== '0) seen = 1;
      respond_step();
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_quiet: activity after abort, expected none");
    end
    n_cmp++;
    if (result !== 4'b0001 || timeout_err !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_partial: result=%b timeout_err=%b expected 0001 / 0000",
               result, timeout_err);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (result !== '0 || timeout_err !== '0) begin
      n_bad++;
      $display("FAIL idle_reset: result=%b timeout_err=%b expected 0000 / 0000", result, timeout_err);
    end
    for (int i = 0; i < NC; i++) set_core(i, 5, 1'b1);
    clear_resp();
    repeat (2) tick();
    core_mask = 4'b1111;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (bist_start !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_reset_launch: bist_start=%b expected 0001", bist_start);
    end
    reset = 1'b0;
    abort = 1'b1;
    tick();
    n_cmp++;
    if ({bist_start, busy, done, result, timeout_err, all_pass, cur_core} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: bist_start=%b busy=%b done=%b result=%b to=%b ap=%b cur=%0d expected all 0",
               bist_start, busy, done, result, timeout_err, all_pass, cur_core);
    end
    reset = 1'b1;
    abort = 1'b0;
    clear_resp();
    tick();
    for (int i = 0; i < NC; i++) set_core(i, $urandom_range(1, 15), 1'b1);
    set_core(3, 9, 1'b0);
    run_session(4'b1011, "post_reset");
  endtask

  task automatic test_random();
    int r;
    logic [NC-1:0] m;
    for (int s = 0; s < 12; s++) begin
      m = NC'($urandom_range(0, 15));
      for (int i = 0; i < NC; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      set_core(i, 0, 1'b1);
        else if (r == 1) set_core(i, $urandom_range(60, 70), $urandom_range(0, 1) == 1);
        else             set_core(i, $urandom_range(1, 40), $urandom_range(0, 3) != 0);
        stuck[i] = ($urandom_range(0, 7) == 0);
      end
      run_session(m, "random");
    end
    stuck = '0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) set_core(i, 1, 1'b1);
    clear_resp();
    test_reset();
    test_all_pass();
    test_fail_core();
    test_timeout();
    test_mid_reset();
    test_timeout_boundary();
    test_stuck_end();
    test_empty_mask();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
